// File: rtl/vx_mem_arb_pkg.sv
// Shared constants, payload type and helpers for the Vortex memory-port arbiter.
package vx_mem_arb_pkg;

  localparam int unsigned DEF_NUM_REQS     = 2;
  localparam int unsigned DEF_ADDR_WIDTH   = 26;
  localparam int unsigned DEF_DATA_WIDTH   = 512;
  localparam int unsigned DEF_BYTEEN_WIDTH = DEF_DATA_WIDTH / 8;
  localparam int unsigned DEF_TAG_IN_WIDTH = 56;

  // Requester-ID width; a single requester still carries one (always zero) ID bit.
  function automatic int unsigned calc_id_width(input int unsigned num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 32'd1;
  endfunction

  localparam int unsigned ID_WIDTH      = calc_id_width(DEF_NUM_REQS);
  localparam int unsigned TAG_OUT_WIDTH = DEF_TAG_IN_WIDTH + ID_WIDTH;

  // Memory-side request payload for the default configuration.
  typedef struct packed {
    logic                        rw;
    logic [DEF_BYTEEN_WIDTH-1:0] byteen;
    logic [DEF_ADDR_WIDTH-1:0]   addr;
    logic [DEF_DATA_WIDTH-1:0]   data;
    logic [TAG_OUT_WIDTH-1:0]    tag;
  } mem_req_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_reqs);
    return (idx + 32'd1 >= num_reqs) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin priority picker: first set bit of valid_i scanning upward from ptr_i, wrapping.
module vx_rr_arbiter
  import vx_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2,
  parameter int unsigned ID_WIDTH = calc_id_width(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQS-1:0] grant_oh_c_o,
  output logic [ID_WIDTH-1:0] grant_idx_c_o,
  output logic                grant_vld_c_o
);

  always_comb begin
    int unsigned         pos;
    logic [NUM_REQS-1:0] shifted;
    pos           = 0;
    shifted       = '0;
    grant_oh_c_o  = '0;
    grant_idx_c_o = '0;
    grant_vld_c_o = 1'b0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= NUM_REQS) pos = pos - NUM_REQS;
      shifted = valid_i >> pos;
      if (!grant_vld_c_o && shifted[0]) begin
        grant_vld_c_o = 1'b1;
        grant_idx_c_o = ID_WIDTH'(pos);
        grant_oh_c_o  = NUM_REQS'(1) << pos;
      end
    end
  end

endmodule

// File: rtl/vx_mem_arbiter.sv
// N-to-1 round-robin arbiter sharing one tagged memory port; requester ID rides in the tag MSBs.
module vx_mem_arbiter
  import vx_mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQS      = 2,
  parameter  int unsigned ADDR_WIDTH    = 26,
  parameter  int unsigned DATA_WIDTH    = 512,
  parameter  int unsigned BYTEEN_WIDTH  = DATA_WIDTH / 8,
  parameter  int unsigned TAG_IN_WIDTH  = 56,
  parameter  int unsigned MAX_PENDING   = 64,
  localparam int unsigned ID_WIDTH      = calc_id_width(NUM_REQS),
  localparam int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + ID_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid_in,
  input  logic [NUM_REQS-1:0]              req_rw_in,
  input  logic [NUM_REQS*BYTEEN_WIDTH-1:0] req_byteen_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
  output logic [NUM_REQS-1:0]              req_ready_in,
  output logic [NUM_REQS-1:0]              rsp_valid_out,
  output logic [NUM_REQS*DATA_WIDTH-1:0]   rsp_data_out,
  output logic [NUM_REQS*TAG_IN_WIDTH-1:0] rsp_tag_out,
  input  logic [NUM_REQS-1:0]              rsp_ready_out,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [BYTEEN_WIDTH-1:0]          mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]         mem_req_tag,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic                             busy,
  output logic                             tag_err
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_PENDING + 1);

  typedef struct packed {
    logic                     rw;
    logic [BYTEEN_WIDTH-1:0]  byteen;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } req_t;

  req_t                req_q, req_d;
  logic                req_vld_q, req_vld_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] pend_q, pend_d;
  logic                tag_err_q, tag_err_d;

  logic                can_load, rd_inflight, pend_ok, rsp_fire, rd_issue, id_ok;
  logic [NUM_REQS-1:0] eligible, grant_oh;
  logic [ID_WIDTH-1:0] grant_idx, rsp_id;
  logic                grant_vld;

  // Response routing by the ID field; unknown IDs are swallowed and flagged.
  always_comb begin
    rsp_id        = mem_rsp_tag[TAG_OUT_WIDTH-1 -: ID_WIDTH];
    rsp_valid_out = '0;
    mem_rsp_ready = 1'b1;
    id_ok         = 1'b0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (rsp_id == ID_WIDTH'(i)) begin
        id_ok            = 1'b1;
        rsp_valid_out[i] = mem_rsp_valid;
        mem_rsp_ready    = rsp_ready_out[i];
      end
    end
  end

  assign rsp_data_out = {NUM_REQS{mem_rsp_data}};
  assign rsp_tag_out  = {NUM_REQS{mem_rsp_tag[TAG_IN_WIDTH-1:0]}};
  assign rsp_fire     = mem_rsp_valid && mem_rsp_ready;
  assign rd_issue     = req_vld_q && mem_req_ready && !req_q.rw;

  // A read parked in the output register is counted so the limit can never be overshot.
  assign can_load    = !req_vld_q || mem_req_ready;
  assign rd_inflight = req_vld_q && !req_q.rw;
  assign pend_ok     = ((32'(pend_q) + 32'(rd_inflight)) < MAX_PENDING) || rsp_fire;
  assign eligible    = req_valid_in & (req_rw_in | {NUM_REQS{pend_ok}});

  vx_rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .valid_i       (eligible),
    .ptr_i         (rr_ptr_q),
    .grant_oh_c_o  (grant_oh),
    .grant_idx_c_o (grant_idx),
    .grant_vld_c_o (grant_vld)
  );

  assign req_ready_in = can_load ? grant_oh : '0;

  always_comb begin
    req_d     = req_q;
    req_vld_d = req_vld_q;
    rr_ptr_d  = rr_ptr_q;
    pend_d    = pend_q;
    tag_err_d = tag_err_q | (mem_rsp_valid && !id_ok);
    if (can_load) begin
      req_vld_d = grant_vld;
      if (grant_vld) begin
        rr_ptr_d = ID_WIDTH'(rr_next(32'(grant_idx), NUM_REQS));
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
          if (grant_oh[i]) begin
            req_d.rw     = req_rw_in[i];
            req_d.byteen = req_byteen_in[i*BYTEEN_WIDTH +: BYTEEN_WIDTH];
            req_d.addr   = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
            req_d.data   = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            req_d.tag    = {ID_WIDTH'(i), req_tag_in[i*TAG_IN_WIDTH +: TAG_IN_WIDTH]};
          end
        end
      end
    end
    if (rd_issue && !rsp_fire) begin
      pend_d = pend_q + CNT_WIDTH'(1);
    end else if (rsp_fire && !rd_issue) begin
      pend_d = pend_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= '0;
      req_vld_q <= 1'b0;
      rr_ptr_q  <= '0;
      pend_q    <= '0;
      tag_err_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      req_vld_q <= req_vld_d;
      rr_ptr_q  <= rr_ptr_d;
      pend_q    <= pend_d;
      tag_err_q <= tag_err_d;
    end
  end

  assign mem_req_valid  = req_vld_q;
  assign mem_req_rw     = req_q.rw;
  assign mem_req_byteen = req_q.byteen;
  assign mem_req_addr   = req_q.addr;
  assign mem_req_data   = req_q.data;
  assign mem_req_tag    = req_q.tag;
  assign busy           = req_vld_q || (pend_q != '0);
  assign tag_err        = tag_err_q;

endmodule

// File: tb/tb_vx_mem_arbiter.sv
// Scoreboard bench: two arbiter instances (2 requesters / 64 pending, 3 requesters / 4 pending).
module tb_vx_mem_arbiter;

  localparam int unsigned AW = 26, DW = 32, BW = 4, TW = 16;
  localparam int unsigned NA = 2, TOA = 17;
  localparam int unsigned NB = 3, TOB = 18;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [127:0] a_q[$];
  logic [127:0] b_q[$];

  logic [NA-1:0] a_req_valid, a_req_rw, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [NA*BW-1:0] a_req_byteen;
  logic [NA*AW-1:0] a_req_addr;
  logic [NA*DW-1:0] a_req_data, a_rsp_data;
  logic [NA*TW-1:0] a_req_tag, a_rsp_tag;
  logic a_mrv, a_mrw, a_mready, a_mrspv, a_mrspr, a_busy, a_terr;
  logic [BW-1:0] a_mbe;
  logic [AW-1:0] a_maddr;
  logic [DW-1:0] a_mdata, a_mrspd;
  logic [TOA-1:0] a_mtag, a_mrspt;

  logic [NB-1:0] b_req_valid, b_req_rw, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [NB*BW-1:0] b_req_byteen;
  logic [NB*AW-1:0] b_req_addr;
  logic [NB*DW-1:0] b_req_data, b_rsp_data;
  logic [NB*TW-1:0] b_req_tag, b_rsp_tag;
  logic b_mrv, b_mrw, b_mready, b_mrspv, b_mrspr, b_busy, b_terr;
  logic [BW-1:0] b_mbe;
  logic [AW-1:0] b_maddr;
  logic [DW-1:0] b_mdata, b_mrspd;
  logic [TOB-1:0] b_mtag, b_mrspt;

  vx_mem_arbiter #(.NUM_REQS(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW),
                   .MAX_PENDING(64)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid_in(a_req_valid), .req_rw_in(a_req_rw), .req_byteen_in(a_req_byteen),
    .req_addr_in(a_req_addr), .req_data_in(a_req_data), .req_tag_in(a_req_tag),
    .req_ready_in(a_req_ready), .rsp_valid_out(a_rsp_valid), .rsp_data_out(a_rsp_data),
    .rsp_tag_out(a_rsp_tag), .rsp_ready_out(a_rsp_ready),
    .mem_req_valid(a_mrv), .mem_req_rw(a_mrw), .mem_req_byteen(a_mbe), .mem_req_addr(a_maddr),
    .mem_req_data(a_mdata), .mem_req_tag(a_mtag), .mem_req_ready(a_mready),
    .mem_rsp_valid(a_mrspv), .mem_rsp_data(a_mrspd), .mem_rsp_tag(a_mrspt),
    .mem_rsp_ready(a_mrspr), .busy(a_busy), .tag_err(a_terr)
  );

  vx_mem_arbiter #(.NUM_REQS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW),
                   .MAX_PENDING(4)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid_in(b_req_valid), .req_rw_in(b_req_rw), .req_byteen_in(b_req_byteen),
    .req_addr_in(b_req_addr), .req_data_in(b_req_data), .req_tag_in(b_req_tag),
    .req_ready_in(b_req_ready), .rsp_valid_out(b_rsp_valid), .rsp_data_out(b_rsp_data),
    .rsp_tag_out(b_rsp_tag), .rsp_ready_out(b_rsp_ready),
    .mem_req_valid(b_mrv), .mem_req_rw(b_mrw), .mem_req_byteen(b_mbe), .mem_req_addr(b_maddr),
    .mem_req_data(b_mdata), .mem_req_tag(b_mtag), .mem_req_ready(b_mready),
    .mem_rsp_valid(b_mrspv), .mem_rsp_data(b_mrspd), .mem_rsp_tag(b_mrspt),
    .mem_rsp_ready(b_mrspr), .busy(b_busy), .tag_err(b_terr)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pk_a(input logic rw, input logic [BW-1:0] be,
      input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [TOA-1:0] t);
    return 128'({rw, be, ad, d, t});
  endfunction

  function automatic logic [127:0] pk_b(input logic rw, input logic [BW-1:0] be,
      input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [TOB-1:0] t);
    return 128'({rw, be, ad, d, t});
  endfunction

  task automatic set_a(input int i, input logic rw, input logic [BW-1:0] be,
      input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [TW-1:0] t);
    a_req_rw[i] = rw;
    a_req_byteen[i*BW +: BW] = be;
    a_req_addr[i*AW +: AW] = ad;
    a_req_data[i*DW +: DW] = d;
    a_req_tag[i*TW +: TW] = t;
  endtask

  task automatic set_b(input int i, input logic rw, input logic [BW-1:0] be,
      input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [TW-1:0] t);
    b_req_rw[i] = rw;
    b_req_byteen[i*BW +: BW] = be;
    b_req_addr[i*AW +: AW] = ad;
    b_req_data[i*DW +: DW] = d;
    b_req_tag[i*TW +: TW] = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every memory-side handshake must match the oldest expected request.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && a_mrv && a_mready) begin
        if (a_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_unexpected_req: got %0h expected none", pk_a(a_mrw, a_mbe, a_maddr, a_mdata, a_mtag));
        end else begin
          chk("a_mem_req", pk_a(a_mrw, a_mbe, a_maddr, a_mdata, a_mtag), a_q.pop_front());
        end
      end
      if (!reset && b_mrv && b_mready) begin
        if (b_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected_req: got %0h expected none", pk_b(b_mrw, b_mbe, b_maddr, b_mdata, b_mtag));
        end else begin
          chk("b_mem_req", pk_b(b_mrw, b_mbe, b_maddr, b_mdata, b_mtag), b_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    a_req_valid = '0; a_req_rw = '0; a_req_byteen = '0; a_req_addr = '0; a_req_data = '0;
    a_req_tag = '0; a_rsp_ready = '0; a_mready = 1'b0; a_mrspv = 1'b0; a_mrspd = '0; a_mrspt = '0;
    b_req_valid = '0; b_req_rw = '0; b_req_byteen = '0; b_req_addr = '0; b_req_data = '0;
    b_req_tag = '0; b_rsp_ready = '0; b_mready = 1'b0; b_mrspv = 1'b0; b_mrspd = '0; b_mrspt = '0;
    reset = 1'b1;
    repeat (2) tick();
    chk("a_rst_valid", a_mrv, 0);
    chk("a_rst_busy", a_busy, 0);
    chk("a_rst_tag_err", a_terr, 0);
    chk("b_rst_valid", b_mrv, 0);
    chk("b_rst_busy", b_busy, 0);
    reset = 1'b0;

    // Two readers held valid: grants alternate 0,1,0,1.
    set_a(0, 1'b0, 4'hF, 26'h100, 32'hA0A0_0000, 16'h0011);
    set_a(1, 1'b0, 4'h3, 26'h200, 32'hB1B1_0000, 16'h0022);
    a_mready = 1'b1;
    a_req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        chk("a_rr_grant", a_req_ready, 2'b01);
        a_q.push_back(pk_a(1'b0, 4'hF, 26'h100, 32'hA0A0_0000, {1'b0, 16'h0011}));
      end else begin
        chk("a_rr_grant", a_req_ready, 2'b10);
        a_q.push_back(pk_a(1'b0, 4'h3, 26'h200, 32'hB1B1_0000, {1'b1, 16'h0022}));
      end
      if (k > 0) begin
        chk("a_pipe_valid", a_mrv, 1);
        chk("a_tag_msb", a_mtag[TOA-1], (k - 1) % 2);
      end else begin
        chk("a_first_latency", a_mrv, 0);
      end
      tick();
    end
    a_req_valid = 2'b00;
    #1;
    chk("a_tag_msb_last", a_mtag[TOA-1], 1);
    tick();

    // Write from requester 1 stalled by memory for three cycles.
    set_a(1, 1'b1, 4'hF, 26'h10, 32'hDEAD_BEEF, 16'h0033);
    a_mready = 1'b0;
    a_req_valid = 2'b10;
    #1;
    chk("a_wr_grant", a_req_ready, 2'b10);
    a_q.push_back(pk_a(1'b1, 4'hF, 26'h10, 32'hDEAD_BEEF, {1'b1, 16'h0033}));
    tick();
    a_req_valid = 2'b01;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) a_mready = 1'b1;
      #1;
      chk("a_hold_valid", a_mrv, 1);
      chk("a_hold_fields", pk_a(a_mrw, a_mbe, a_maddr, a_mdata, a_mtag),
          pk_a(1'b1, 4'hF, 26'h10, 32'hDEAD_BEEF, {1'b1, 16'h0033}));
      if (c == 3) begin
        chk("a_release_ready", a_req_ready, 2'b01);
        a_q.push_back(pk_a(1'b0, 4'hF, 26'h100, 32'hA0A0_0000, {1'b0, 16'h0011}));
      end else begin
        chk("a_stall_ready", a_req_ready, 2'b00);
      end
      tick();
    end
    a_req_valid = 2'b00;
    tick();

    // Response to requester 1 with back-pressure, then drain all five reads.
    a_mrspv = 1'b1;
    a_mrspt = {1'b1, 16'h0ABC};
    a_mrspd = 32'h1234_5678;
    a_rsp_ready = 2'b01;
    #1;
    chk("a_rsp_route", a_rsp_valid, 2'b10);
    chk("a_rsp_backpressure", a_mrspr, 0);
    chk("a_rsp_tag_bcast", a_rsp_tag, {16'h0ABC, 16'h0ABC});
    chk("a_rsp_data_bcast", a_rsp_data, {32'h1234_5678, 32'h1234_5678});
    tick();
    chk("a_busy_pending", a_busy, 1);
    a_rsp_ready = 2'b10;
    #1;
    chk("a_rsp_ready_up", a_mrspr, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      a_mrspt = {1'(k % 2), 16'(k)};
      a_rsp_ready = 2'b11;
      #1;
      chk("a_rsp_route_k", a_rsp_valid, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk("a_busy_drain", a_busy, 1);
      tick();
    end
    a_mrspv = 1'b0;
    #1;
    chk("a_busy_idle", a_busy, 0);

    // Reset while a write is stalled; the pointer must return to requester 0.
    set_a(0, 1'b1, 4'h1, 26'h3F, 32'h0BAD_0000, 16'h0055);
    set_a(1, 1'b1, 4'h2, 26'h2F, 32'h0CAB_0000, 16'h0066);
    a_mready = 1'b0;
    a_req_valid = 2'b01;
    #1;
    chk("a_pre_rst_grant", a_req_ready, 2'b01);
    tick();
    a_req_valid = 2'b00;
    #1;
    chk("a_stall_busy", a_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("a_rst_mid_valid", a_mrv, 0);
    chk("a_rst_mid_busy", a_busy, 0);
    a_mready = 1'b1;
    a_req_valid = 2'b11;
    #1;
    chk("a_rst_rr_ptr", a_req_ready, 2'b01);
    a_q.push_back(pk_a(1'b1, 4'h1, 26'h3F, 32'h0BAD_0000, {1'b0, 16'h0055}));
    tick();
    a_req_valid = 2'b00;
    tick();

    // Pending-read limit of 4 on the 3-requester instance.
    set_b(0, 1'b0, 4'hF, 26'h40, 32'hC0C0_0000, 16'h0044);
    b_mready = 1'b1;
    b_req_valid = 3'b001;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("b_rd_grant", b_req_ready, 3'b001);
      b_q.push_back(pk_b(1'b0, 4'hF, 26'h40, 32'hC0C0_0000, {2'd0, 16'h0044}));
      tick();
    end
    b_req_valid = 3'b000;
    tick();
    tick();
    set_b(1, 1'b0, 4'hF, 26'h80, 32'hD0D0_0000, 16'h0066);
    set_b(2, 1'b1, 4'h7, 26'h90, 32'hE0E0_0000, 16'h0077);
    b_req_valid = 3'b110;
    #1;
    chk("b_throttle_wr", b_req_ready, 3'b100);
    b_q.push_back(pk_b(1'b1, 4'h7, 26'h90, 32'hE0E0_0000, {2'd2, 16'h0077}));
    tick();
    b_req_valid = 3'b010;
    #1;
    chk("b_throttle_rd", b_req_ready, 3'b000);
    tick();
    chk("b_throttle_rd_hold", b_req_ready, 3'b000);
    b_mrspv = 1'b1;
    b_mrspt = {2'd0, 16'h0044};
    b_rsp_ready = 3'b111;
    #1;
    chk("b_rsp_route", b_rsp_valid, 3'b001);
    chk("b_rsp_unblocks_rd", b_req_ready, 3'b010);
    b_q.push_back(pk_b(1'b0, 4'hF, 26'h80, 32'hD0D0_0000, {2'd1, 16'h0066}));
    tick();
    b_req_valid = 3'b000;
    b_mrspv = 1'b0;
    tick();

    // Response carrying ID 3 with only three requesters.
    b_mrspv = 1'b1;
    b_mrspt = {2'd3, 16'h0077};
    b_rsp_ready = 3'b000;
    #1;
    chk("b_bad_id_ready", b_mrspr, 1);
    chk("b_bad_id_route", b_rsp_valid, 3'b000);
    chk("b_tag_err_pre", b_terr, 0);
    tick();
    b_mrspv = 1'b0;
    #1;
    chk("b_tag_err_set", b_terr, 1);
    tick();
    chk("b_tag_err_sticky", b_terr, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("b_tag_err_clear", b_terr, 0);
    chk("b_rst_busy_end", b_busy, 0);
    tick();

    chk("a_sb_empty", a_q.size(), 0);
    chk("b_sb_empty", b_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
